// File: rtl/idex_pipe_reg.sv
// rtl/idex_pipe_reg.sv - ID->EX pipeline register with valid, stall, flush and immediate extension.
// Optional stall/bubble performance counters are enabled by defining IDEX_PERF_CNT_EN.
module idex_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int RADDR_W = 5,
    parameter int ALUOP_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               S1_valid,
    input  logic [DATA_W-1:0]  S1_readData1,
    input  logic [DATA_W-1:0]  S1_readData2,
    input  logic [IMM_W-1:0]   S1_Imm,
    input  logic               S1_ImmSext,
    input  logic [ALUOP_W-1:0] S1_ALUOp,
    input  logic               S1_DataSource,
    input  logic [RADDR_W-1:0] S1_writeselect,
    input  logic               S1_WriteEnable,
    output logic               S2_valid,
    output logic [DATA_W-1:0]  S2_readData1,
    output logic [DATA_W-1:0]  S2_readData2,
    output logic [DATA_W-1:0]  S2_Imm,
    output logic [ALUOP_W-1:0] S2_ALUOp,
    output logic               S2_DataSource,
    output logic [RADDR_W-1:0] S2_writeselect,
    output logic               S2_WriteEnable
`ifdef IDEX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    logic [DATA_W-1:0]  w_imm_ext;

    logic               r_valid;
    logic [DATA_W-1:0]  r_readData1;
    logic [DATA_W-1:0]  r_readData2;
    logic [DATA_W-1:0]  r_imm;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_datasource;
    logic [RADDR_W-1:0] r_writeselect;
    logic               r_writeenable;

    generate
        if (IMM_W == DATA_W) begin : g_imm_pass
            assign w_imm_ext = S1_Imm;
        end else begin : g_imm_ext
            assign w_imm_ext = S1_ImmSext
                ? {{(DATA_W-IMM_W){S1_Imm[IMM_W-1]}}, S1_Imm}
                : {{(DATA_W-IMM_W){1'b0}}, S1_Imm};
        end
    endgenerate

    // Priority: reset > flush > stall > load. A flush during stall discards the held instruction.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid       <= 1'b0;
            r_readData1   <= '0;
            r_readData2   <= '0;
            r_imm         <= '0;
            r_aluop       <= '0;
            r_datasource  <= 1'b0;
            r_writeselect <= '0;
            r_writeenable <= 1'b0;
        end else if (!stall) begin
            r_valid       <= S1_valid;
            r_readData1   <= S1_readData1;
            r_readData2   <= S1_readData2;
            r_imm         <= w_imm_ext;
            r_aluop       <= S1_ALUOp;
            r_datasource  <= S1_DataSource;
            r_writeselect <= S1_writeselect;
            r_writeenable <= S1_WriteEnable & S1_valid;
        end
    end

    assign S2_valid       = r_valid;
    assign S2_readData1   = r_readData1;
    assign S2_readData2   = r_readData2;
    assign S2_Imm         = r_imm;
    assign S2_ALUOp       = r_aluop;
    assign S2_DataSource  = r_datasource;
    assign S2_writeselect = r_writeselect;
    assign S2_WriteEnable = r_writeenable;

`ifdef IDEX_PERF_CNT_EN
    logic             w_stall_inc;
    logic             w_bubble_inc;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    // A bubble is any edge that loads S2_valid = 0: a flush, or an unstalled load of an invalid slot.
    assign w_stall_inc  = stall & ~flush;
    assign w_bubble_inc = flush | (~stall & ~S1_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bubble_inc && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb/tb_idex_pipe_reg.sv - randomized self-checking bench for idex_pipe_reg against a behavioural model.
module tb_idex_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int IMM_W   = 16;
    localparam int RADDR_W = 5;
    localparam int ALUOP_W = 3;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset, stall, flush;
    logic               S1_valid, S1_ImmSext, S1_DataSource, S1_WriteEnable;
    logic [DATA_W-1:0]  S1_readData1, S1_readData2;
    logic [IMM_W-1:0]   S1_Imm;
    logic [ALUOP_W-1:0] S1_ALUOp;
    logic [RADDR_W-1:0] S1_writeselect;

    logic               S2_valid, S2_DataSource, S2_WriteEnable;
    logic [DATA_W-1:0]  S2_readData1, S2_readData2, S2_Imm;
    logic [ALUOP_W-1:0] S2_ALUOp;
    logic [RADDR_W-1:0] S2_writeselect;
`ifdef IDEX_PERF_CNT_EN
    logic [CNT_W-1:0]   stall_cnt, bubble_cnt;
    logic [1:0]         sat_stall_cnt, sat_bubble_cnt;
    logic               sat_valid, sat_ds, sat_we;
    logic [DATA_W-1:0]  sat_rd1, sat_rd2, sat_imm;
    logic [ALUOP_W-1:0] sat_aluop;
    logic [RADDR_W-1:0] sat_ws;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state: the architectural content of stage 2.
    logic               m_valid, m_ds, m_we;
    logic [DATA_W-1:0]  m_rd1, m_rd2, m_imm;
    logic [ALUOP_W-1:0] m_aluop;
    logic [RADDR_W-1:0] m_ws;
    longint             m_scnt, m_bcnt, m_sat_scnt;

    always #5 clk = ~clk;

    idex_pipe_reg #(.DATA_W(DATA_W), .IMM_W(IMM_W), .RADDR_W(RADDR_W),
                    .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .S1_valid(S1_valid), .S1_readData1(S1_readData1), .S1_readData2(S1_readData2),
        .S1_Imm(S1_Imm), .S1_ImmSext(S1_ImmSext), .S1_ALUOp(S1_ALUOp),
        .S1_DataSource(S1_DataSource), .S1_writeselect(S1_writeselect),
        .S1_WriteEnable(S1_WriteEnable),
        .S2_valid(S2_valid), .S2_readData1(S2_readData1), .S2_readData2(S2_readData2),
        .S2_Imm(S2_Imm), .S2_ALUOp(S2_ALUOp), .S2_DataSource(S2_DataSource),
        .S2_writeselect(S2_writeselect), .S2_WriteEnable(S2_WriteEnable)
`ifdef IDEX_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

`ifdef IDEX_PERF_CNT_EN
    idex_pipe_reg #(.DATA_W(DATA_W), .IMM_W(IMM_W), .RADDR_W(RADDR_W),
                    .ALUOP_W(ALUOP_W), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .S1_valid(S1_valid), .S1_readData1(S1_readData1), .S1_readData2(S1_readData2),
        .S1_Imm(S1_Imm), .S1_ImmSext(S1_ImmSext), .S1_ALUOp(S1_ALUOp),
        .S1_DataSource(S1_DataSource), .S1_writeselect(S1_writeselect),
        .S1_WriteEnable(S1_WriteEnable),
        .S2_valid(sat_valid), .S2_readData1(sat_rd1), .S2_readData2(sat_rd2),
        .S2_Imm(sat_imm), .S2_ALUOp(sat_aluop), .S2_DataSource(sat_ds),
        .S2_writeselect(sat_ws), .S2_WriteEnable(sat_we),
        .stall_cnt(sat_stall_cnt), .bubble_cnt(sat_bubble_cnt)
    );
`endif

    function automatic longint sat_inc(longint v, int width);
        longint top = (longint'(1) << width) - 1;
        return (v >= top) ? top : v + 1;
    endfunction

    // Applies one clock edge to the model using the current inputs.
    task automatic model_edge();
        longint raw;
        if (reset) begin
            {m_valid, m_ds, m_we, m_rd1, m_rd2, m_imm, m_aluop, m_ws} = '0;
            m_scnt = 0; m_bcnt = 0; m_sat_scnt = 0;
        end else if (flush) begin
            {m_valid, m_ds, m_we, m_rd1, m_rd2, m_imm, m_aluop, m_ws} = '0;
            m_bcnt = sat_inc(m_bcnt, CNT_W);
        end else if (stall) begin
            m_scnt = sat_inc(m_scnt, CNT_W);
            m_sat_scnt = sat_inc(m_sat_scnt, 2);
        end else begin
            raw = longint'(S1_Imm);
            if (S1_ImmSext && raw >= (longint'(1) << (IMM_W - 1)))
                raw = raw - (longint'(1) << IMM_W);
            m_imm   = DATA_W'(raw);
            m_valid = S1_valid;
            m_we    = S1_valid ? S1_WriteEnable : 1'b0;
            m_rd1   = S1_readData1;
            m_rd2   = S1_readData2;
            m_aluop = S1_ALUOp;
            m_ds    = S1_DataSource;
            m_ws    = S1_writeselect;
            if (!S1_valid) m_bcnt = sat_inc(m_bcnt, CNT_W);
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_s1(logic v, logic [31:0] rd1, logic [31:0] rd2, logic [15:0] imm,
                          logic sext, logic [2:0] op, logic ds, logic [4:0] ws, logic we);
        S1_valid = v; S1_readData1 = rd1; S1_readData2 = rd2; S1_Imm = imm;
        S1_ImmSext = sext; S1_ALUOp = op; S1_DataSource = ds;
        S1_writeselect = ws; S1_WriteEnable = we;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        set_s1(1'b1, 32'hFFFF_FFFF, 32'hAAAA_5555, 16'hFFFF, 1'b1, 3'h7, 1'b1, 5'h1F, 1'b1);
        cycle();
        cycle();
        checks++;
        if ({S2_valid, S2_readData1, S2_readData2, S2_Imm, S2_ALUOp, S2_DataSource,
             S2_writeselect, S2_WriteEnable} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b rd1=%h rd2=%h imm=%h op=%h ds=%b ws=%h we=%b, required all 0",
                     S2_valid, S2_readData1, S2_readData2, S2_Imm, S2_ALUOp, S2_DataSource,
                     S2_writeselect, S2_WriteEnable);
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_counters: got stall_cnt=%0d bubble_cnt=%0d, required 0 0", stall_cnt, bubble_cnt);
        end
`endif
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_load_sext();
        set_s1(1'b1, 32'h1234_5678, 32'h0BAD_F00D, 16'h8001, 1'b1, 3'h2, 1'b1, 5'd7, 1'b1);
        cycle();
        checks++;
        if (S2_Imm !== 32'hFFFF_8001 || S2_WriteEnable !== 1'b1 || S2_writeselect !== 5'd7 ||
            S2_valid !== 1'b1 || S2_readData1 !== 32'h1234_5678) begin
            failures++;
            $display("FAIL load_sext: got imm=%h we=%b ws=%0d valid=%b rd1=%h, required FFFF8001 1 7 1 12345678",
                     S2_Imm, S2_WriteEnable, S2_writeselect, S2_valid, S2_readData1);
        end
    endtask

    task automatic test_load_zext();
        S1_ImmSext = 1'b0;
        cycle();
        checks++;
        if (S2_Imm !== 32'h0000_8001) begin
            failures++;
            $display("FAIL load_zext: got imm=%h, required 00008001", S2_Imm);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        S1_readData1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (S2_readData1 !== 32'h1234_5678 || S2_valid !== 1'b1 || S2_Imm !== 32'h0000_8001) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got rd1=%h valid=%b imm=%h, required 12345678 1 00008001",
                         i, S2_readData1, S2_valid, S2_Imm);
            end
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL stall_cnt: got %0d, required 3", stall_cnt);
        end
`endif
    endtask

    task automatic test_flush();
        stall = 1'b1; flush = 1'b1;
        S1_valid = 1'b1; S1_WriteEnable = 1'b1;
        cycle();
        checks++;
        if ({S2_valid, S2_readData1, S2_readData2, S2_Imm, S2_ALUOp, S2_DataSource,
             S2_writeselect, S2_WriteEnable} !== '0) begin
            failures++;
            $display("FAIL flush_bubble: got valid=%b we=%b rd1=%h imm=%h ws=%h, required all 0",
                     S2_valid, S2_WriteEnable, S2_readData1, S2_Imm, S2_writeselect);
        end
`ifdef IDEX_PERF_CNT_EN
        checks++;
        if (bubble_cnt !== 16'd1 || stall_cnt !== 16'd3) begin
            failures++;
            $display("FAIL flush_counters: got bubble_cnt=%0d stall_cnt=%0d, required 1 3", bubble_cnt, stall_cnt);
        end
`endif
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_invalid_no_write();
        set_s1(1'b0, 32'h5555_0000, 32'h0000_5555, 16'h1234, 1'b1, 3'h5, 1'b0, 5'd3, 1'b1);
        cycle();
        checks++;
        if (S2_WriteEnable !== 1'b0 || S2_valid !== 1'b0 || S2_readData1 !== 32'h5555_0000) begin
            failures++;
            $display("FAIL invalid_no_write: got we=%b valid=%b rd1=%h, required 0 0 55550000",
                     S2_WriteEnable, S2_valid, S2_readData1);
        end
    endtask

    task automatic test_reset_mid_stall();
        stall = 1'b1; flush = 1'b1; reset = 1'b1;
        cycle();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_s1(1'b1, 32'hCAFE_0001, 32'h0000_0002, 16'h7FFF, 1'b1, 3'h1, 1'b0, 5'd9, 1'b1);
        cycle();
        checks++;
        if (S2_valid !== 1'b1 || S2_readData1 !== 32'hCAFE_0001 || S2_Imm !== 32'h0000_7FFF ||
            S2_writeselect !== 5'd9) begin
            failures++;
            $display("FAIL reset_then_load: got valid=%b rd1=%h imm=%h ws=%0d, required 1 CAFE0001 00007FFF 9",
                     S2_valid, S2_readData1, S2_Imm, S2_writeselect);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 3) == 0);
            set_s1(1'($urandom), $urandom, $urandom, 16'($urandom), 1'($urandom), 3'($urandom),
                   1'($urandom), 5'($urandom), 1'($urandom));
            cycle();
            checks++;
            if ({S2_valid, S2_readData1, S2_readData2, S2_Imm, S2_ALUOp, S2_DataSource,
                 S2_writeselect, S2_WriteEnable} !==
                {m_valid, m_rd1, m_rd2, m_imm, m_aluop, m_ds, m_ws, m_we}) begin
                failures++;
                $display("FAIL random[%0d]: got v=%b rd1=%h rd2=%h imm=%h op=%h ds=%b ws=%h we=%b, required v=%b rd1=%h rd2=%h imm=%h op=%h ds=%b ws=%h we=%b",
                         i, S2_valid, S2_readData1, S2_readData2, S2_Imm, S2_ALUOp, S2_DataSource,
                         S2_writeselect, S2_WriteEnable, m_valid, m_rd1, m_rd2, m_imm, m_aluop,
                         m_ds, m_ws, m_we);
            end
`ifdef IDEX_PERF_CNT_EN
            checks++;
            if (stall_cnt !== CNT_W'(m_scnt) || bubble_cnt !== CNT_W'(m_bcnt)) begin
                failures++;
                $display("FAIL random_cnt[%0d]: got stall=%0d bubble=%0d, required stall=%0d bubble=%0d",
                         i, stall_cnt, bubble_cnt, m_scnt, m_bcnt);
            end
`endif
        end
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

`ifdef IDEX_PERF_CNT_EN
    task automatic test_saturation();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        cycle();
        reset = 1'b0; stall = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cycle();
            checks++;
            if (sat_stall_cnt !== 2'(m_sat_scnt) || sat_stall_cnt !== 2'((i > 3) ? 3 : i)) begin
                failures++;
                $display("FAIL sat_stall_cnt[%0d]: got %0d, required %0d", i, sat_stall_cnt, (i > 3) ? 3 : i);
            end
        end
        stall = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        set_s1(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        {m_valid, m_ds, m_we, m_rd1, m_rd2, m_imm, m_aluop, m_ws} = '0;
        m_scnt = 0; m_bcnt = 0; m_sat_scnt = 0;
        @(negedge clk);
        test_reset();
        test_load_sext();
        test_load_zext();
        test_stall();
        test_flush();
        test_invalid_no_write();
        test_reset_mid_stall();
        test_random();
`ifdef IDEX_PERF_CNT_EN
        test_saturation();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
